// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM line responder and its wait counter:
//   - state_t           : responder FSM states
//   - BASE_ADDR_DEFAULT : byte address of the first SRAM data word
//   - WAIT_CYCLES_DEFAULT : default clock cycles per SRAM word access
//   - SRAM_ADDR_W / SRAM_DATA_W : off-chip SRAM address and data widths
//   - WAIT_CNT_W        : width of the per-access wait counter
//   - byte_to_word()    : byte address to untruncated word index
// ----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned BASE_ADDR_DEFAULT   = 1024;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 5;
    localparam int unsigned SRAM_ADDR_W         = 17;
    localparam int unsigned SRAM_DATA_W         = 32;
    localparam int unsigned WAIT_CNT_W          = 4;

    // The caller truncates the result to the SRAM address width, which
    // makes addresses outside the SRAM wrap around silently.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
// Down-counter that times a single SRAM word access.
// Ports:
//   clk        : pipeline clock
//   rst_n      : asynchronous reset, active low (count returns to 0)
//   load       : reload count with load_value (takes priority over enable)
//   load_value : cycles remaining minus one for the access being entered
//   enable     : decrement while an access is in progress
//   terminal   : high during the last cycle of the access (count == 0)
// ----------------------------------------------------------------------------
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_value,
    input  logic                  enable,
    output logic                  terminal
);

    logic [WAIT_CNT_W-1:0] count;

    // Count holds at zero instead of wrapping, so a state that lingers
    // past its terminal cycle never sees a bogus second terminal pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/sram_line_responder.sv
// ----------------------------------------------------------------------------
// sram_line_responder
// Responder side of the cache-controller request/ready handshake. Serves
// single-word writes and 64-bit line reads (two word accesses) on an
// asynchronous SRAM, stretching each access to WAIT_CYCLES clocks.
// Ports:
//   clk       : pipeline clock, all state on rising edge
//   rst       : asynchronous reset, active low
//   r_en      : line-read request, held until ready
//   w_en      : word-write request, held until ready (wins over r_en)
//   address   : byte address of the request
//   wdata     : write word
//   rdata     : last line read, {odd word, even word}
//   ready     : one-cycle completion pulse
//   SRAM_DQ   : bidirectional SRAM data bus, driven only while writing
//   SRAM_ADDR : SRAM word address
//   SRAM_WE_N : SRAM write enable, active low
// ----------------------------------------------------------------------------
module sram_line_responder
    import sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int unsigned ADDR_W      = SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   r_en,
    input  logic                   w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [63:0]            rdata,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_W-1:0]      idx_q;
    logic [SRAM_DATA_W-1:0] wdata_q;
    logic                   wait_load;
    logic                   wait_enable;
    logic                   wait_done;
    logic                   dq_drive;

    // Reloading on every state change gives each access a fresh count,
    // including the second half of a line read.
    assign wait_load   = (state_next != state);
    assign wait_enable = (state == RD_LO) || (state == RD_HI) || (state == WR);

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (wait_load),
        .load_value (WAIT_CNT_W'(WAIT_CYCLES - 1)),
        .enable     (wait_enable),
        .terminal   (wait_done)
    );

    // State register; reset drops straight to IDLE, which also releases
    // the bus and deasserts write enable mid-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a write request takes precedence over a read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_en) begin
                    state_next = WR;
                end else if (r_en) begin
                    state_next = RD_LO;
                end
            end
            RD_LO:   if (wait_done) state_next = RD_HI;
            RD_HI:   if (wait_done) state_next = DONE;
            WR:      if (wait_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture at acceptance; the requester may change address and
    // wdata afterwards without disturbing the access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            wdata_q <= '0;
        end else if ((state == IDLE) && (w_en || r_en)) begin
            idx_q   <= ADDR_W'(byte_to_word(address, 32'(BASE_ADDR)));
            wdata_q <= wdata;
        end
    end

    // Read data is sampled on the last cycle of each half so the SRAM has
    // had the full wait-state time to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (wait_done) begin
            case (state)
                RD_LO:   rdata[31:0]  <= SRAM_DQ;
                RD_HI:   rdata[63:32] <= SRAM_DQ;
                default: ;
            endcase
        end
    end

    // Output decode; a line read always covers an even/odd word pair.
    always_comb begin
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_drive  = 1'b0;
        case (state)
            RD_LO: SRAM_ADDR = {idx_q[ADDR_W-1:1], 1'b0};
            RD_HI: SRAM_ADDR = {idx_q[ADDR_W-1:1], 1'b1};
            WR: begin
                SRAM_ADDR = idx_q;
                SRAM_WE_N = 1'b0;
                dq_drive  = 1'b1;
            end
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    assign SRAM_DQ = dq_drive ? wdata_q : 'z;

endmodule
